// File: rtl/light_part_cm_update.sv
`default_nettype none
// ============================================================================
// Module   : light_part_cm_update
// Brief    : Elastic-sketch light part. Folds evicted {key, count} words into
//            a one-row count-min table of saturating counters through a
//            3-stage read-modify-write pipeline, serves key queries, and
//            zero-fills the table after every reset.
// Revision : 1.0 - initial release
// ============================================================================
module light_part_cm_update #(
  parameter int ADDR_W     = 12,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ALF_LEVEL  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ip_addr_value_in_wr,
  input  logic [95:0]      ip_addr_value_in,
  output logic             ip_addr_value_in_alf,
  input  logic             query_rd,
  input  logic [63:0]      query_key,
  output logic             query_value_wr,
  output logic [CNT_W-1:0] query_value,
  output logic             init_done,
  output logic             overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int NSL   = (64 + ADDR_W - 1) / ADDR_W;
  localparam int PADW  = NSL * ADDR_W;

  localparam logic [ADDR_W-1:0] SWEEP_LAST = '1;
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W:0]    OCC_FULL   = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    OCC_ALF    = (PTR_W + 1)'(ALF_LEVEL);
  localparam logic [32:0]       SAT33      = {{(33 - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // XOR-fold of the key into ADDR_W-bit slices, top slice zero-padded.
  function automatic logic [ADDR_W-1:0] hash_f(input logic [63:0] key);
    logic [PADW-1:0]   kp;
    logic [ADDR_W-1:0] h;
    kp = PADW'(key);
    h  = '0;
    for (int s = 0; s < NSL; s++) begin
      h = h ^ kp[s*ADDR_W +: ADDR_W];
    end
    return h;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------- state
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              init_done_q, init_done_d;

  // ---------------------------------------------------------------- FIFO
  logic [95:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   occ_q;
  logic             overflow_q;

  // ---------------------------------------------------------------- pipeline
  logic              a_valid_q, a_upd_q, a_valid_d, a_upd_d;
  logic [ADDR_W-1:0] a_idx_q, a_idx_d;
  logic [31:0]       a_cnt_q, a_cnt_d;
  logic              b_valid_q, b_upd_q;
  logic [ADDR_W-1:0] b_idx_q;
  logic [31:0]       b_cnt_q;
  logic [CNT_W-1:0]  ram_rd_q;
  logic              lw_valid_q;
  logic [ADDR_W-1:0] lw_idx_q;
  logic [CNT_W-1:0]  lw_data_q;
  logic              qv_wr_q;
  logic [CNT_W-1:0]  qv_q;

  logic [CNT_W-1:0]  ram [DEPTH];

  logic              w_run, w_empty, w_full, w_qissue, w_pop, w_push_req, w_push, w_drop;
  logic [95:0]       w_head;
  logic [CNT_W-1:0]  w_fwd, w_new;
  logic [32:0]       w_sum;
  logic              w_cwrite, w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [CNT_W-1:0]  w_wdata;

  assign w_run      = (state_q == ST_RUN);
  assign w_empty    = (occ_q == '0);
  assign w_full     = (occ_q == OCC_FULL);
  assign w_qissue   = w_run && query_rd;
  assign w_pop      = w_run && !query_rd && !w_empty;
  assign w_push_req = w_run && ip_addr_value_in_wr;
  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_head     = fifo_mem[rd_ptr_q];

  // Init sweep: one zero write per cycle, then hand over to normal operation.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == SWEEP_LAST) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
    end
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (w_push) fifo_mem[wr_ptr_q] <= ip_addr_value_in;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (w_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({w_push, w_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (w_drop) overflow_q <= 1'b1;
    end
  end

  // Stage A issue: queries win over queued updates.
  always_comb begin
    a_valid_d = w_qissue || w_pop;
    a_upd_d   = !w_qissue;
    a_idx_d   = w_qissue ? hash_f(query_key) : hash_f(w_head[95:32]);
    a_cnt_d   = w_head[31:0];
  end

  // Stage C compute: forward last cycle's write over the stale RAM read.
  always_comb begin
    w_fwd    = (lw_valid_q && (lw_idx_q == b_idx_q)) ? lw_data_q : ram_rd_q;
    w_sum    = {{(33 - CNT_W){1'b0}}, w_fwd} + {1'b0, b_cnt_q};
    w_new    = (w_sum > SAT33) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    w_cwrite = b_valid_q && b_upd_q;
    w_we     = !reset && (w_run ? w_cwrite : 1'b1);
    w_waddr  = w_run ? b_idx_q : sweep_q;
    w_wdata  = w_run ? w_new : '0;
  end

  // Pipeline stage registers, forwarding record and query response.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      lw_valid_q <= 1'b0;
      qv_wr_q    <= 1'b0;
      qv_q       <= '0;
    end else begin
      a_valid_q  <= a_valid_d;
      b_valid_q  <= a_valid_q;
      lw_valid_q <= w_cwrite;
      qv_wr_q    <= b_valid_q && !b_upd_q;
      if (b_valid_q && !b_upd_q) qv_q <= w_fwd;
    end
    a_upd_q   <= a_upd_d;
    a_idx_q   <= a_idx_d;
    a_cnt_q   <= a_cnt_d;
    b_upd_q   <= a_upd_q;
    b_idx_q   <= a_idx_q;
    b_cnt_q   <= a_cnt_q;
    lw_idx_q  <= b_idx_q;
    lw_data_q <= w_new;
  end

  // Counter RAM: registered read, read-during-write returns old data.
  always_ff @(posedge clk) begin
    if (w_we) ram[w_waddr] <= w_wdata;
    ram_rd_q <= ram[a_idx_q];
  end

  assign ip_addr_value_in_alf = (occ_q >= OCC_ALF) || !w_run;
  assign query_value_wr       = qv_wr_q;
  assign query_value          = qv_q;
  assign init_done            = init_done_q;
  assign overflow             = overflow_q;

endmodule
`default_nettype wire

// File: doc/light_part_cm_update.md
Name: light_part_cm_update

Overview:
- Downstream consumer of the last heavy-part table stage in the elastic sketch pipeline.
- Accepts evicted/overflowed {flow key, count} words and folds them into a one-row count-min "light part" of saturating 8-bit counters held in on-chip RAM.
- Runs as a 3-stage read-modify-write pipeline fed by a small input FIFO with almost-full backpressure.
- Also serves key queries and zero-initialises the RAM after every reset.

Parameters:
- ADDR_W, 12, counter index width; DEPTH = 2^ADDR_W.
- CNT_W, 8, counter width; saturates at 2^CNT_W-1.
- FIFO_DEPTH, 16, input FIFO entries.
- ALF_LEVEL, 12, FIFO occupancy at or above which almost-full asserts.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ip_addr_value_in_wr  in  1  input word valid, one word per cycle
- ip_addr_value_in  in  96  [95:32] flow key (64b), [31:0] count to add
- ip_addr_value_in_alf  out  1  almost-full to upstream
- query_rd  in  1  query request
- query_key  in  64  key to look up
- query_value_wr  out  1  query response valid
- query_value  out  CNT_W  counter value for the queried key
- init_done  out  1  RAM sweep complete
- overflow  out  1  sticky: a word arrived while the FIFO was full

Behaviour:
- One clock domain. reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values:
  - ip_addr_value_in_alf=1, query_value_wr=0, query_value=0, init_done=0, overflow=0.
  - FIFO emptied, pipeline valids cleared, FSM to INIT with sweep address 0.
- FSM:
  - INIT: writes 0 to RAM address sweep_addr each cycle, sweep_addr+1. After writing DEPTH-1 it moves to RUN and sets init_done=1. Takes exactly DEPTH cycles.
  - In INIT, ip_addr_value_in_alf stays 1; input words and query_rd are ignored (not enqueued, no response).
  - RUN: normal operation. Only reset leaves RUN.
- Hash: index = XOR of consecutive ADDR_W-bit slices of the 64-bit key, starting at bit 0, last slice zero-padded at its top.
  - With ADDR_W=12: k[11:0]^k[23:12]^k[35:24]^k[47:36]^k[59:48]^{8'b0,k[63:60]}.
- Input FIFO:
  - Write on ip_addr_value_in_wr when not full. A write while full is dropped and sets overflow (sticky until reset).
  - ip_addr_value_in_alf = (occupancy >= ALF_LEVEL) or INIT. Upstream may issue at most FIFO_DEPTH-ALF_LEVEL words after alf rises.
  - Simultaneous push and pop at full: the pop frees a slot, so the push succeeds.
- Pipeline (RUN only):
  - Stage A: issue slot. query_rd has priority; otherwise pop the FIFO if non-empty. Registers op type (update/query), index and count. Issues at most one op per cycle.
  - Stage B: index drives the RAM read address (registered RAM, 1-cycle read latency).
  - Stage C: q is valid.
    - Forwarding: if stage C wrote the same index in the previous cycle, use that written value instead of q.
    - Update op: new = min(fwd + count, 2^CNT_W-1), computed at 33-bit width so there is no wrap. The write happens this cycle, including when count=0.
    - Query op: no write. query_value_wr=1 and query_value=fwd, registered, so they appear on the next cycle.
- Latencies:
  - RAM write occurs 3 cycles after the FIFO pop.
  - query_value_wr is asserted exactly 3 cycles after an accepted query_rd.
- Read-during-write to the same address returns the old data. Single-stage forwarding covers all back-to-back hazards; sustained throughput is 1 op/cycle.
- No ordering between queries and queued updates beyond issue order: a query sees all updates issued before it.
- Reset mid-operation: in-flight ops and FIFO contents are discarded and the RAM is re-zeroed by INIT.

Test Plan:
- Reset, hold inputs idle → alf=1 and init_done=0 for 4096 cycles, then init_done=1 and alf=0. Query any key → value 0.
- Update key 0x0000_0000_0000_0003 with count 5; query same key → query_value_wr exactly 3 cycles after query_rd, value 5. Query key 0x...0004 → 0.
- Updates with counts 200 then 100 to one key → query returns 255. A further count 0xFFFF_FFFF → still 255 (no wrap).
- Back-to-back updates with counts 1, 2, 3 on keys 0x1 and 0x1000 (both index 1), then an immediate query of key 0x1 → 6, proving forwarding.
- Hold query_rd high while pushing 16 words with alf ignored → alf rises at occupancy 12. The 17th word while full sets overflow=1. After releasing query_rd the FIFO drains and all 16 words apply.
- Assert reset while the FIFO holds 8 words and 2 ops are in flight → no RAM writes from them; after re-init, queries of those keys return 0 and overflow=0.
